// File: rtl/adder_share_ctrl.sv
// Round-robin controller that time-shares one WIDTH-bit adder between NUM_REQ
// requesters and returns a registered, ID-tagged result over valid/ready.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | arbitrate from rr_ptr; accept the granted operands
// S_EXEC | one-cycle add, load the result registers
// S_RESP | result held on rsp_* until rsp_ready
module adder_share_ctrl #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 2,
  localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_sat,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_carry,
  output logic [IDW-1:0]           rsp_id,
  output logic                     busy
);

  localparam int SW = IDW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           state_q;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] op_a_q, op_b_q;
  logic             op_sat_q;
  logic [IDW-1:0]   op_id_q;
  logic             rsp_valid_q, rsp_carry_q, busy_q;
  logic [WIDTH-1:0] rsp_sum_q;
  logic [IDW-1:0]   rsp_id_q;

  logic             grant_found;
  logic [IDW-1:0]   grant_idx;
  logic [SW-1:0]    slot;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic             sel_sat;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] sum_d;

  // Slot is the rotated search position, reduced modulo NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    slot        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      slot = {1'b0, rr_ptr_q} + SW'(k);
      if (slot >= SW'(NUM_REQ)) begin
        slot = slot - SW'(NUM_REQ);
      end
      if (!grant_found && req_valid[slot[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = slot[IDW-1:0];
      end
    end
  end

  always_comb begin
    if (grant_idx == IDW'(NUM_REQ - 1)) begin
      rr_ptr_d = '0;
    end else begin
      rr_ptr_d = grant_idx + IDW'(1);
    end
  end

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_sat = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_idx == IDW'(k)) begin
        sel_a   = req_a[k*WIDTH +: WIDTH];
        sel_b   = req_b[k*WIDTH +: WIDTH];
        sel_sat = req_sat[k];
      end
    end
  end

  // Ready is masked during reset so no handshake can complete on a reset edge.
  always_comb begin
    req_ready = '0;
    if ((state_q == S_IDLE) && grant_found && !rst) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign sum_ext = {1'b0, op_a_q} + {1'b0, op_b_q};
  assign sum_d   = (op_sat_q && sum_ext[WIDTH]) ? '1 : sum_ext[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_sat_q    <= 1'b0;
      op_id_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_carry_q <= 1'b0;
      rsp_id_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (grant_found) begin
            op_a_q   <= sel_a;
            op_b_q   <= sel_b;
            op_sat_q <= sel_sat;
            op_id_q  <= grant_idx;
            rr_ptr_q <= rr_ptr_d;
            state_q  <= S_EXEC;
            busy_q   <= 1'b1;
          end
        end
        S_EXEC: begin
          rsp_sum_q   <= sum_d;
          rsp_carry_q <= sum_ext[WIDTH];
          rsp_id_q    <= op_id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Self-checking bench for adder_share_ctrl: directed scenarios on 2- and
// 3-requester instances plus randomized traffic against a behavioural model.
module tb_adder_share_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       rsp_ready = 1'b1;
  logic       use3 = 1'b0;
  logic [2:0] valid = 3'b000;
  logic [2:0] sat = 3'b000;
  logic [7:0] opa [3];
  logic [7:0] opb [3];
  logic [23:0] a_bus, b_bus;
  assign a_bus = {opa[2], opa[1], opa[0]};
  assign b_bus = {opb[2], opb[1], opb[0]};

  logic [1:0] v2_in;
  logic [2:0] v3_in;
  assign v2_in = use3 ? 2'b00 : valid[1:0];
  assign v3_in = use3 ? valid : 3'b000;

  logic [1:0] r2;
  logic       rv2, c2, id2, b2;
  logic [7:0] s2;
  logic [2:0] r3;
  logic       rv3, c3, b3;
  logic [1:0] id3;
  logic [7:0] s3;

  adder_share_ctrl #(.WIDTH(8), .NUM_REQ(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(v2_in), .req_ready(r2),
    .req_a(a_bus[15:0]), .req_b(b_bus[15:0]), .req_sat(sat[1:0]),
    .rsp_valid(rv2), .rsp_ready(rsp_ready), .rsp_sum(s2),
    .rsp_carry(c2), .rsp_id(id2), .busy(b2)
  );

  adder_share_ctrl #(.WIDTH(8), .NUM_REQ(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(v3_in), .req_ready(r3),
    .req_a(a_bus), .req_b(b_bus), .req_sat(sat),
    .rsp_valid(rv3), .rsp_ready(rsp_ready), .rsp_sum(s3),
    .rsp_carry(c3), .rsp_id(id3), .busy(b3)
  );

  logic [2:0] obs_ready;
  logic       obs_valid, obs_carry, obs_busy;
  logic [7:0] obs_sum;
  logic [1:0] obs_id;
  assign obs_ready = use3 ? r3 : {1'b0, r2};
  assign obs_valid = use3 ? rv3 : rv2;
  assign obs_carry = use3 ? c3 : c2;
  assign obs_busy  = use3 ? b3 : b2;
  assign obs_sum   = use3 ? s3 : s2;
  assign obs_id    = use3 ? id3 : {1'b0, id2};

  int errors = 0;
  int checks = 0;

  task automatic do_reset();
    rst = 1'b1;
    valid = 3'b000;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    use3 = 1'b0;
    do_reset();
    #1;
    checks++; if (obs_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", obs_busy); end
    checks++; if (obs_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", obs_valid); end
    checks++; if (obs_sum !== 8'h00) begin errors++; $display("FAIL reset_sum: got %h expected 00", obs_sum); end
    checks++; if (obs_carry !== 1'b0) begin errors++; $display("FAIL reset_carry: got %b expected 0", obs_carry); end
    checks++; if (obs_id !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d expected 0", obs_id); end
    checks++; if (obs_ready !== 3'b000) begin errors++; $display("FAIL reset_ready: got %b expected 000", obs_ready); end
    @(negedge clk);
  endtask

  task automatic test_single_op(input int idx, input logic [7:0] a, input logic [7:0] b,
                                input logic s, input logic [7:0] e_sum, input logic e_carry);
    logic [2:0] er;
    er = 3'b000;
    er[idx] = 1'b1;
    valid = er;
    opa[idx] = a;
    opb[idx] = b;
    sat[idx] = s;
    rsp_ready = 1'b1;
    #1;
    checks++; if (obs_ready !== er) begin errors++; $display("FAIL op_ready: got %b expected %b", obs_ready, er); end
    @(negedge clk);
    valid = 3'b000;
    opa[idx] = ~a;
    opb[idx] = 8'($urandom);
    #1;
    checks++; if (obs_busy !== 1'b1 || obs_valid !== 1'b0 || obs_ready !== 3'b000)
      begin errors++; $display("FAIL op_exec: got busy=%b valid=%b ready=%b expected 1 0 000", obs_busy, obs_valid, obs_ready); end
    @(negedge clk);
    #1;
    checks++; if (obs_valid !== 1'b1) begin errors++; $display("FAIL op_rsp_valid: got %b expected 1", obs_valid); end
    checks++; if (obs_sum !== e_sum) begin errors++; $display("FAIL op_sum: got %h expected %h", obs_sum, e_sum); end
    checks++; if (obs_carry !== e_carry) begin errors++; $display("FAIL op_carry: got %b expected %b", obs_carry, e_carry); end
    checks++; if (obs_id !== 2'(idx)) begin errors++; $display("FAIL op_id: got %0d expected %0d", obs_id, idx); end
    @(negedge clk);
    #1;
    checks++; if (obs_valid !== 1'b0 || obs_busy !== 1'b0 || obs_sum !== e_sum)
      begin errors++; $display("FAIL op_after: got valid=%b busy=%b sum=%h expected 0 0 %h", obs_valid, obs_busy, obs_sum, e_sum); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back(input logic sel3, input logic [2:0] vmask);
    int grants[$];
    int gcyc[$];
    int ids[$];
    int exp_g [4];
    use3 = sel3;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      opa[i] = 8'($urandom);
      opb[i] = 8'($urandom);
    end
    valid = vmask;
    for (int c = 0; c < 12; c++) begin
      #1;
      checks++; if ((obs_ready & (obs_ready - 3'd1)) != 3'b000 || (obs_busy && obs_ready != 3'b000))
        begin errors++; $display("FAIL b2b_onehot: got ready=%b busy=%b expected at most one bit, none while busy", obs_ready, obs_busy); end
      for (int k = 0; k < 3; k++) if (obs_ready[k]) begin grants.push_back(k); gcyc.push_back(c); end
      if (obs_valid) ids.push_back(int'(obs_id));
      @(negedge clk);
    end
    valid = 3'b000;
    exp_g[0] = 0; exp_g[2] = 0;
    exp_g[1] = sel3 ? 2 : 1; exp_g[3] = exp_g[1];
    checks++; if (grants.size() != 4 || ids.size() != 4)
      begin errors++; $display("FAIL b2b_count: got grants=%0d rsps=%0d expected 4 4", grants.size(), ids.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (grants[i] != exp_g[i] || gcyc[i] != 3 * i || ids[i] != exp_g[i])
          begin errors++; $display("FAIL b2b_seq%0d: got grant=%0d at cycle %0d id=%0d expected %0d at %0d", i, grants[i], gcyc[i], ids[i], exp_g[i], 3 * i); end
      end
    end
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    use3 = 1'b0;
    do_reset();
    valid = 3'b001; opa[0] = 8'hC8; opb[0] = 8'h64; sat[0] = 1'b1;
    rsp_ready = 1'b0;
    #1;
    checks++; if (obs_ready !== 3'b001) begin errors++; $display("FAIL bp_grant0: got %b expected 001", obs_ready); end
    @(negedge clk);
    valid = 3'b010; opa[1] = 8'h05; opb[1] = 8'h06; sat[1] = 1'b0;
    #1;
    checks++; if (obs_busy !== 1'b1 || obs_ready !== 3'b000) begin errors++; $display("FAIL bp_exec: got busy=%b ready=%b expected 1 000", obs_busy, obs_ready); end
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (obs_valid !== 1'b1 || obs_sum !== 8'hFF || obs_carry !== 1'b1 || obs_id !== 2'd0 || obs_ready !== 3'b000 || obs_busy !== 1'b1)
        begin errors++; $display("FAIL bp_hold%0d: got v=%b sum=%h c=%b id=%0d rdy=%b busy=%b expected 1 ff 1 0 000 1", c, obs_valid, obs_sum, obs_carry, obs_id, obs_ready, obs_busy); end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (obs_valid !== 1'b1) begin errors++; $display("FAIL bp_release: got %b expected 1", obs_valid); end
    @(negedge clk);
    #1;
    checks++; if (obs_busy !== 1'b0 || obs_valid !== 1'b0 || obs_ready !== 3'b010)
      begin errors++; $display("FAIL bp_regrant: got busy=%b valid=%b ready=%b expected 0 0 010", obs_busy, obs_valid, obs_ready); end
    @(negedge clk);
    valid = 3'b000;
    @(negedge clk);
    #1;
    checks++; if (obs_valid !== 1'b1 || obs_sum !== 8'h0B || obs_id !== 2'd1)
      begin errors++; $display("FAIL bp_second: got v=%b sum=%h id=%0d expected 1 0b 1", obs_valid, obs_sum, obs_id); end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_exec();
    use3 = 1'b0;
    do_reset();
    valid = 3'b010; opa[1] = 8'h33; opb[1] = 8'h44; sat[1] = 1'b0;
    #1;
    checks++; if (obs_ready !== 3'b010) begin errors++; $display("FAIL rme_grant1: got %b expected 010", obs_ready); end
    @(negedge clk);
    rst = 1'b1;
    valid = 3'b000;
    #1;
    checks++; if (obs_busy !== 1'b1) begin errors++; $display("FAIL rme_exec: got busy=%b expected 1", obs_busy); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (obs_valid !== 1'b0 || obs_busy !== 1'b0 || obs_sum !== 8'h00)
      begin errors++; $display("FAIL rme_cleared: got v=%b busy=%b sum=%h expected 0 0 00", obs_valid, obs_busy, obs_sum); end
    valid = 3'b011; opa[0] = 8'h01; opb[0] = 8'h02; sat[0] = 1'b0;
    #1;
    checks++; if (obs_ready !== 3'b001) begin errors++; $display("FAIL rme_ptr0: got %b expected 001", obs_ready); end
    @(negedge clk);
    valid = 3'b000;
    @(negedge clk);
    #1;
    checks++; if (obs_valid !== 1'b1 || obs_id !== 2'd0 || obs_sum !== 8'h03)
      begin errors++; $display("FAIL rme_rsp: got v=%b id=%0d sum=%h expected 1 0 03", obs_valid, obs_id, obs_sum); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      checks++; if (obs_valid !== 1'b0) begin errors++; $display("FAIL rme_norsp%0d: got %b expected 0", c, obs_valid); end
    end
    @(negedge clk);
  endtask

  task automatic test_wrap3();
    use3 = 1'b1;
    do_reset();
    valid = 3'b100; opa[2] = 8'h10; opb[2] = 8'h20;
    #1;
    checks++; if (obs_ready !== 3'b100) begin errors++; $display("FAIL wrap_grant2: got %b expected 100", obs_ready); end
    @(negedge clk);
    valid = 3'b000;
    @(negedge clk);
    @(negedge clk);
    valid = 3'b111;
    #1;
    checks++; if (obs_ready !== 3'b001) begin errors++; $display("FAIL wrap_ptr0: got %b expected 001", obs_ready); end
    @(negedge clk);
    valid = 3'b000;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_random(input int n, input int ncyc);
    bit pend [3];
    int pa [3], pb [3], ps [3];
    bit mf;
    int mage, mptr, g, idx, s;
    int cur_sum, cur_carry, cur_id, last_sum, last_carry, last_id;
    int es, ec, ei;
    bit ev;
    logic [2:0] er;
    use3 = (n == 3);
    do_reset();
    mf = 0; mage = 0; mptr = 0;
    cur_sum = 0; cur_carry = 0; cur_id = 0;
    last_sum = 0; last_carry = 0; last_id = 0;
    for (int i = 0; i < 3; i++) begin pend[i] = 0; pa[i] = 0; pb[i] = 0; ps[i] = 0; end
    for (int c = 0; c < ncyc; c++) begin
      for (int i = 0; i < n; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1;
          pa[i] = $urandom_range(0, 255);
          pb[i] = $urandom_range(0, 255);
          ps[i] = $urandom_range(0, 1);
        end
      end
      for (int i = 0; i < 3; i++) begin
        valid[i] = (i < n) && pend[i];
        opa[i] = 8'(pa[i]);
        opb[i] = 8'(pb[i]);
        sat[i] = ps[i][0];
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 59) == 0);
      #1;
      g = -1;
      if (!mf) begin
        for (int k = 0; k < n; k++) begin
          idx = (mptr + k) % n;
          if (g < 0 && pend[idx]) g = idx;
        end
      end
      er = 3'b000;
      if (g >= 0) er[g] = 1'b1;
      ev = mf && (mage >= 1);
      es = ev ? cur_sum : last_sum;
      ec = ev ? cur_carry : last_carry;
      ei = ev ? cur_id : last_id;
      if (!rst) begin
        checks++; if (obs_ready !== er) begin errors++; $display("FAIL rnd_ready n=%0d cyc=%0d: got %b expected %b", n, c, obs_ready, er); end
      end
      checks++; if (obs_valid !== ev || obs_busy !== mf)
        begin errors++; $display("FAIL rnd_ctrl n=%0d cyc=%0d: got valid=%b busy=%b expected %b %b", n, c, obs_valid, obs_busy, ev, mf); end
      checks++; if (obs_sum !== 8'(es) || obs_carry !== ec[0] || obs_id !== 2'(ei))
        begin errors++; $display("FAIL rnd_data n=%0d cyc=%0d: got sum=%h c=%b id=%0d expected %h %0d %0d", n, c, obs_sum, obs_carry, obs_id, es, ec, ei); end
      if (rst) begin
        mf = 0; mptr = 0;
        last_sum = 0; last_carry = 0; last_id = 0;
      end else if (!mf) begin
        if (g >= 0) begin
          s = pa[g] + pb[g];
          cur_carry = (s > 255) ? 1 : 0;
          cur_sum = (ps[g] != 0 && s > 255) ? 255 : s % 256;
          cur_id = g;
          mf = 1; mage = 0;
          mptr = (g + 1) % n;
          pend[g] = 0;
        end
      end else if (mage >= 1 && rsp_ready) begin
        mf = 0;
        last_sum = cur_sum; last_carry = cur_carry; last_id = cur_id;
      end else begin
        mage = 1;
      end
      @(negedge clk);
    end
    rst = 1'b0;
    do_reset();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin opa[i] = 8'h00; opb[i] = 8'h00; end
    test_reset();
    test_single_op(0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);
    test_single_op(1, 8'hF0, 8'h20, 1'b0, 8'h10, 1'b1);
    test_single_op(1, 8'hF0, 8'h20, 1'b1, 8'hFF, 1'b1);
    test_back_to_back(1'b0, 3'b011);
    test_backpressure();
    test_reset_mid_exec();
    test_back_to_back(1'b1, 3'b101);
    test_wrap3();
    test_random(2, 400);
    test_random(3, 400);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
